// File: rtl/max7219_ctrl_pkg.sv
// Shared definitions for the MAX7219 daisy-chain driver: FSM states and MAX7219 register addresses.
package max7219_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShiftLow,
    StShiftHigh,
    StHold,
    StLatch,
    StDone
  } ctrl_state_e;

  localparam logic [7:0] AddrNoop      = 8'h00;
  localparam logic [7:0] AddrDigit0    = 8'h01;
  localparam logic [7:0] AddrDigit1    = 8'h02;
  localparam logic [7:0] AddrDigit2    = 8'h03;
  localparam logic [7:0] AddrDigit3    = 8'h04;
  localparam logic [7:0] AddrDigit4    = 8'h05;
  localparam logic [7:0] AddrDigit5    = 8'h06;
  localparam logic [7:0] AddrDigit6    = 8'h07;
  localparam logic [7:0] AddrDigit7    = 8'h08;
  localparam logic [7:0] AddrDecode    = 8'h09;
  localparam logic [7:0] AddrIntensity = 8'h0A;
  localparam logic [7:0] AddrScanLimit = 8'h0B;
  localparam logic [7:0] AddrShutdown  = 8'h0C;
  localparam logic [7:0] AddrTest      = 8'h0F;

  function automatic logic [15:0] cmd_word(input logic [7:0] addr, input logic [7:0] data);
    return {addr, data};
  endfunction

endpackage

// File: rtl/max7219_tick_gen.sv
// Divider that pulses o_tick on the last cycle of every G_CLK_DIV-cycle window while enabled.
module max7219_tick_gen #(
  parameter int unsigned G_CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned   DivW    = (G_CLK_DIV > 1) ? $clog2(G_CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(G_CLK_DIV - 1);

  logic [DivW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || !i_en) begin
      cnt_q <= '0;
    end else if (cnt_q == DivLast) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DivW'(1);
    end
  end

  assign o_tick = i_en && (cnt_q == DivLast);

endmodule

// File: rtl/max7219_daisy_chain_ctrl.sv
// Shifts one 16-bit command word per matrix into a MAX7219 daisy chain, then pulses LOAD.
module max7219_daisy_chain_ctrl
  import max7219_ctrl_pkg::*;
#(
  parameter int unsigned G_NB_MATRIX = 8,
  parameter int unsigned G_CLK_DIV   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  input  logic [16*G_NB_MATRIX-1:0] i_data,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_max7219_clk,
  output logic                      o_max7219_din,
  output logic                      o_max7219_load
);

  localparam int unsigned NbBits = 16 * G_NB_MATRIX;
  localparam int unsigned CntW   = $clog2(NbBits + 1);

  ctrl_state_e       state_q, state_d;
  logic [NbBits-1:0] shift_q, shift_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sclk_q, sclk_d;
  logic              din_q, din_d;
  logic              load_q, load_d;
  logic              tick_en;
  logic              tick;

  assign tick_en = (state_q inside {StSetup, StShiftLow, StShiftHigh, StHold, StLatch});

  max7219_tick_gen #(
    .G_CLK_DIV(G_CLK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (tick_en),
    .o_tick(tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          shift_d   = i_data;
          bit_cnt_d = CntW'(NbBits);
          state_d   = StSetup;
        end
      end
      StSetup:    if (tick) state_d = StShiftLow;
      StShiftLow: if (tick) state_d = StShiftHigh;
      StShiftHigh: begin
        if (tick) begin
          shift_d   = {shift_q[NbBits-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q - CntW'(1);
          state_d   = (bit_cnt_q == CntW'(1)) ? StHold : StShiftLow;
        end
      end
      StHold:  if (tick) state_d = StLatch;
      StLatch: if (tick) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so they stay registered yet align with it.
    busy_d = (state_d inside {StSetup, StShiftLow, StShiftHigh, StHold, StLatch});
    done_d = (state_d == StDone);
    sclk_d = (state_d == StShiftHigh);
    din_d  = (state_d inside {StShiftLow, StShiftHigh}) ? shift_d[NbBits-1] : 1'b0;
    load_d = !(state_d inside {StSetup, StShiftLow, StShiftHigh, StHold});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      din_q     <= 1'b0;
      load_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      din_q     <= din_d;
      load_q    <= load_d;
    end
  end

  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_max7219_clk  = sclk_q;
  assign o_max7219_din  = din_q;
  assign o_max7219_load = load_q;

endmodule

// File: tb/tb_max7219_daisy_chain_ctrl.sv
// Bench: three driver instances (N=2/D=2, N=8/D=4, N=1/D=1) observed through a behavioural chain model.
module tb_max7219_daisy_chain_ctrl;
  import max7219_ctrl_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   sel = 2'd0;
  logic [31:0]  data_a = '0;
  logic [127:0] data_b = '0;
  logic [15:0]  data_c = '0;

  logic a_busy, a_done, a_sclk, a_din, a_load;
  logic b_busy, b_done, b_sclk, b_din, b_load;
  logic c_busy, c_done, c_sclk, c_din, c_load;
  logic m_busy, m_done, m_sclk, m_din, m_load;
  int   mon_d;

  int checks = 0;
  int failures = 0;

  max7219_daisy_chain_ctrl #(.G_NB_MATRIX(2), .G_CLK_DIV(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_start(start && (sel == 2'd0)), .i_data(data_a),
    .o_busy(a_busy), .o_done(a_done), .o_max7219_clk(a_sclk), .o_max7219_din(a_din),
    .o_max7219_load(a_load)
  );

  max7219_daisy_chain_ctrl #(.G_NB_MATRIX(8), .G_CLK_DIV(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_start(start && (sel == 2'd1)), .i_data(data_b),
    .o_busy(b_busy), .o_done(b_done), .o_max7219_clk(b_sclk), .o_max7219_din(b_din),
    .o_max7219_load(b_load)
  );

  max7219_daisy_chain_ctrl #(.G_NB_MATRIX(1), .G_CLK_DIV(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .i_start(start && (sel == 2'd2)), .i_data(data_c),
    .o_busy(c_busy), .o_done(c_done), .o_max7219_clk(c_sclk), .o_max7219_din(c_din),
    .o_max7219_load(c_load)
  );

  always #5 clk = ~clk;

  always_comb begin
    {m_busy, m_done, m_sclk, m_din, m_load} = {a_busy, a_done, a_sclk, a_din, a_load};
    mon_d = 2;
    case (sel)
      2'd1: begin
        {m_busy, m_done, m_sclk, m_din, m_load} = {b_busy, b_done, b_sclk, b_din, b_load};
        mon_d = 4;
      end
      2'd2: begin
        {m_busy, m_done, m_sclk, m_din, m_load} = {c_busy, c_done, c_sclk, c_din, c_load};
        mon_d = 1;
      end
      default: ;
    endcase
  end

  // Chain model: every rising serial clock shifts din in; a rising LOAD latches every device.
  logic         mon_clr = 1'b0;
  logic         prev_sclk, prev_din, prev_load, prev_busy, gap_armed;
  int           cyc, fall_t, sclk_rises, loads, dones, viol;
  int           busy_run, bmin, bmax, gap_run, gmin, gmax;
  logic [127:0] chain, latched;
  logic [7:0]   digit_mem [8][8];
  logic [7:0]   exp_mem [8][8];

  always @(negedge clk) begin
    if (mon_clr) begin
      cyc <= 0; fall_t <= 0; sclk_rises <= 0; loads <= 0; dones <= 0; viol <= 0;
      busy_run <= 0; bmin <= 100000; bmax <= 0; gap_run <= 0; gmin <= 100000; gmax <= 0;
      gap_armed <= 1'b0; chain <= '0; latched <= '0;
      prev_sclk <= m_sclk; prev_din <= m_din; prev_load <= m_load; prev_busy <= m_busy;
      for (int k = 0; k < 8; k++) for (int j = 0; j < 8; j++) digit_mem[k][j] <= 8'h00;
    end else begin
      cyc <= cyc + 1;
      prev_sclk <= m_sclk; prev_din <= m_din; prev_load <= m_load; prev_busy <= m_busy;
      if (m_sclk && !prev_sclk) begin
        chain <= {chain[126:0], m_din};
        sclk_rises <= sclk_rises + 1;
        if (m_din != prev_din) viol <= viol + 1;
      end
      if (m_sclk && prev_sclk && (m_din != prev_din)) viol <= viol + 1;
      if (!m_sclk && prev_sclk) fall_t <= cyc;
      if (m_load && !prev_load) begin
        latched <= chain;
        loads <= loads + 1;
        if (cyc - fall_t < mon_d) viol <= viol + 1;
        if (sel == 2'd1) begin
          for (int k = 0; k < 8; k++) begin
            if (chain[16*k+8 +: 8] inside {[8'd1:8'd8]})
              digit_mem[k][chain[16*k+8 +: 8] - 8'd1] <= chain[16*k +: 8];
          end
        end
      end
      if (m_busy) begin
        busy_run <= busy_run + 1;
      end else if (prev_busy) begin
        if (busy_run < bmin) bmin <= busy_run;
        if (busy_run > bmax) bmax <= busy_run;
        busy_run <= 0;
      end
      if (m_done) begin
        dones <= dones + 1;
        gap_run <= 0;
        gap_armed <= 1'b1;
      end else if (!m_busy) begin
        gap_run <= gap_run + 1;
      end
      if (m_busy && !prev_busy && gap_armed) begin
        if (gap_run < gmin) gmin <= gap_run;
        if (gap_run > gmax) gmax <= gap_run;
        gap_armed <= 1'b0;
      end
    end
  end

  task automatic mon_clear;
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic pulse_start;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_dones(input int target, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (dones >= target) break;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b1;
    data_a = $urandom;
    repeat (5) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      checks++; if (m_sclk !== 1'b0) begin failures++; $display("FAIL reset_clk[%0d] got %b want 0", s, m_sclk); end
      checks++; if (m_din !== 1'b0) begin failures++; $display("FAIL reset_din[%0d] got %b want 0", s, m_din); end
      checks++; if (m_load !== 1'b1) begin failures++; $display("FAIL reset_load[%0d] got %b want 1", s, m_load); end
      checks++; if (m_busy !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d] got %b want 0", s, m_busy); end
      checks++; if (m_done !== 1'b0) begin failures++; $display("FAIL reset_done[%0d] got %b want 0", s, m_done); end
    end
    sel = 2'd0;
    start = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    mon_clear();
    repeat (6) @(negedge clk);
    #1;
    checks++; if (sclk_rises != 0) begin failures++; $display("FAIL reset_no_clk got %0d want 0", sclk_rises); end
    checks++; if (m_busy !== 1'b0) begin failures++; $display("FAIL reset_no_busy got %b want 0", m_busy); end
  endtask

  task automatic test_frame_n2;
    logic [31:0] exp;
    sel = 2'd0;
    for (int r = 0; r < 3; r++) begin
      exp = (r == 0) ? {cmd_word(AddrIntensity, 8'h0F), cmd_word(AddrShutdown, 8'h01)} : $urandom;
      data_a = exp;
      mon_clear();
      pulse_start();
      wait_dones(1, 400);
      repeat (3) @(negedge clk);
      #1;
      checks++; if (dones != 1) begin failures++; $display("FAIL n2_done[%0d] got %0d want 1", r, dones); end
      checks++; if (sclk_rises != 32) begin failures++; $display("FAIL n2_clks[%0d] got %0d want 32", r, sclk_rises); end
      checks++; if (bmin != 134 || bmax != 134) begin failures++; $display("FAIL n2_busy[%0d] got %0d..%0d want 134", r, bmin, bmax); end
      checks++; if (latched[31:16] !== exp[31:16]) begin failures++; $display("FAIL n2_matrix1[%0d] got %h want %h", r, latched[31:16], exp[31:16]); end
      checks++; if (latched[15:0] !== exp[15:0]) begin failures++; $display("FAIL n2_matrix0[%0d] got %h want %h", r, latched[15:0], exp[15:0]); end
      checks++; if (viol != 0) begin failures++; $display("FAIL n2_ordering[%0d] got %0d want 0", r, viol); end
    end
  endtask

  task automatic test_digits_n8;
    int a, d;
    sel = 2'd1;
    mon_clear();
    for (int j = 0; j < 8; j++) begin
      for (int k = 0; k < 8; k++) begin
        data_b[16*k +: 16] = cmd_word(AddrDigit0 + 8'(j), 8'hA5);
        exp_mem[k][j] = 8'hA5;
      end
      pulse_start();
      wait_dones(j + 1, 1200);
    end
    #1;
    checks++; if (loads != 8) begin failures++; $display("FAIL n8_frames got %0d want 8", loads); end
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 8; k++) begin
        a = $urandom_range(0, 8);
        d = $urandom_range(0, 255);
        data_b[16*k +: 16] = cmd_word(8'(a), 8'(d));
        if (a != 0) exp_mem[k][a-1] = 8'(d);
      end
      pulse_start();
      wait_dones(9 + f, 1200);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (dones != 12) begin failures++; $display("FAIL n8_done got %0d want 12", dones); end
    checks++; if (bmin != 1036 || bmax != 1036) begin failures++; $display("FAIL n8_busy got %0d..%0d want 1036", bmin, bmax); end
    checks++; if (viol != 0) begin failures++; $display("FAIL n8_ordering got %0d want 0", viol); end
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 8; j++) begin
        checks++;
        if (digit_mem[k][j] !== exp_mem[k][j]) begin
          failures++;
          $display("FAIL n8_digit m%0d d%0d got %h want %h", k, j, digit_mem[k][j], exp_mem[k][j]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    sel = 2'd2;
    data_c = 16'($urandom);
    mon_clear();
    @(posedge clk);
    #1 start = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (dones >= 3) break;
    end
    start = 1'b0;
    repeat (50) @(negedge clk);
    #1;
    checks++; if (dones != 3) begin failures++; $display("FAIL b2b_done got %0d want 3", dones); end
    checks++; if (bmin != 35 || bmax != 35) begin failures++; $display("FAIL b2b_busy got %0d..%0d want 35", bmin, bmax); end
    checks++; if (gmin != 1 || gmax != 1) begin failures++; $display("FAIL b2b_idle_gap got %0d..%0d want 1", gmin, gmax); end
    checks++; if (sclk_rises != 48) begin failures++; $display("FAIL b2b_clks got %0d want 48", sclk_rises); end
    checks++; if (latched[15:0] !== data_c) begin failures++; $display("FAIL b2b_word got %h want %h", latched[15:0], data_c); end
    checks++; if (viol != 0) begin failures++; $display("FAIL b2b_ordering got %0d want 0", viol); end
  endtask

  task automatic test_data_change;
    logic [31:0] exp;
    sel = 2'd0;
    exp = $urandom;
    data_a = exp;
    mon_clear();
    pulse_start();
    repeat (20) @(posedge clk);
    #1 data_a = ~exp;
    wait_dones(1, 400);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (dones != 1) begin failures++; $display("FAIL chg_done got %0d want 1", dones); end
    checks++; if (latched[31:0] !== exp) begin failures++; $display("FAIL chg_word got %h want %h", latched[31:0], exp); end
  endtask

  task automatic test_reset_mid_frame;
    bit reached;
    sel = 2'd0;
    data_a = $urandom;
    mon_clear();
    pulse_start();
    reached = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (sclk_rises == 11 && m_sclk) begin reached = 1'b1; break; end
    end
    checks++; if (!reached) begin failures++; $display("FAIL mid_reach got %0d want 11", sclk_rises); end
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checks++; if ({m_busy, m_done, m_sclk, m_din, m_load} !== 5'b00001) begin
      failures++; $display("FAIL mid_idle got %b want 00001", {m_busy, m_done, m_sclk, m_din, m_load});
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    checks++; if (dones != 0) begin failures++; $display("FAIL mid_no_done got %0d want 0", dones); end
    data_a = $urandom;
    mon_clear();
    pulse_start();
    wait_dones(1, 400);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (dones != 1) begin failures++; $display("FAIL mid_next_done got %0d want 1", dones); end
    checks++; if (latched[31:0] !== data_a) begin failures++; $display("FAIL mid_next_word got %h want %h", latched[31:0], data_a); end
    checks++; if (bmax != 134) begin failures++; $display("FAIL mid_next_busy got %0d want 134", bmax); end
  endtask

  initial begin
    test_reset();
    test_frame_n2();
    test_digits_n8();
    test_back_to_back();
    test_data_change();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/max7219_daisy_chain_ctrl.md
Name: max7219_daisy_chain_ctrl

Overview:
- Synthesizable serial driver that shifts one 16-bit MAX7219 command word per matrix into a daisy chain of G_NB_MATRIX devices, then pulses LOAD to latch all words at once.
- Sits directly upstream of the MAX7219 checker wrapper in the matrix benches, and upstream of the real display chain on the board.
- Its o_max7219_clk, o_max7219_din and o_max7219_load outputs drive the chain's i_max7219_clk, i_max7219_din and i_max7219_load inputs.

Parameters:
- G_NB_MATRIX, 8: number of chained MAX7219 devices; must be >= 1.
- G_CLK_DIV, 4: duration of one MAX7219 clock half-period, in clk cycles (D); must be >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- i_start  in  1  frame request; sampled only in IDLE.
- i_data  in  16*G_NB_MATRIX  command words; bits [16k+15:16k] are matrix k's word ({addr[15:8], data[7:0]}), matrix 0 being nearest the driver.
- o_busy  out  1  high while a frame is in progress.
- o_done  out  1  one-cycle pulse when a frame completes.
- o_max7219_clk  out  1  serial clock to the chain.
- o_max7219_din  out  1  serial data to matrix 0.
- o_max7219_load  out  1  LOAD/CS; the chain latches on its rising edge.

Behaviour:
- Reset values: o_busy=0, o_done=0, o_max7219_clk=0, o_max7219_din=0, o_max7219_load=1. All outputs are registered.
- Reset mid-frame: outputs return to their reset values on the next edge; the frame is abandoned and no o_done is generated.
- Tick generator: a divider counter counts 0..D-1. Each state lasts exactly D cycles and advances on the tick.
- IDLE: on a clk edge with i_start=1, capture i_data into the shift register, load the bit counter with B=16*G_NB_MATRIX, go to SETUP. From the next cycle o_busy=1 and load=0.
- SETUP (D cycles): load=0, clk=0, din=0.
- SHIFT_LOW (D cycles): clk=0; din = current shift-register MSB, valid from the first cycle of the state.
- SHIFT_HIGH (D cycles): clk=1; din stable.
  - At the end: shift left by 1 and decrement the bit counter.
  - If the counter is nonzero, go to SHIFT_LOW; otherwise go to HOLD.
- Shift order: bit 16*G_NB_MATRIX-1 first (matrix G_NB_MATRIX-1's MSB), bit 0 last. After B clocks, matrix k holds word k.
- HOLD (D cycles): clk=0, load=0, din=0.
- LATCH (D cycles): load=1, clk=0, busy still 1.
- DONE: one cycle; o_busy=0 and o_done=1 in the same cycle, then IDLE.
  - A start in the DONE cycle is ignored.
  - A start in the following IDLE cycle is accepted.
- Busy duration: exactly D*(2B+3) cycles. Example: N=8, D=4 gives 1036 cycles.
- Signal ordering:
  - din changes only while clk=0; the rising clk edge always falls mid-bit.
  - load rises at least D cycles after the last clk falling edge.
- i_start is ignored while busy. i_data is sampled only at start and may change during a frame.
- Widths: bit counter is $clog2(B+1) bits; divider is max(1, $clog2(D)) bits.

Decomposition:
- Shared package max7219_ctrl_pkg:
  - state enum {IDLE, SETUP, SHIFT_LOW, SHIFT_HIGH, HOLD, LATCH, DONE};
  - MAX7219 address constants: NOOP=8'h00, DIGIT_0..7=8'h01..08, DECODE=8'h09, INTENSITY=8'h0A, SCAN_LIMIT=8'h0B, SHUTDOWN=8'h0C, TEST=8'h0F.
- One sub-module, max7219_tick_gen: parameter G_CLK_DIV; ports clk, rst_n, i_en, o_tick. It asserts o_tick on the last cycle of each D-cycle window and clears its count when i_en=0.

Test Plan:
1. Reset: hold rst_n=0 for 5 cycles -> clk=0, din=0, load=1, busy=0, done=0. Start while in reset -> no activity.
2. N=2, D=2, i_data={16'h0A0F,16'h0C01}, one start pulse:
   - 32 clk rising edges; din sequence 0x0A0F then 0x0C01, MSB first;
   - busy for 2*(64+3)=134 cycles; a single done pulse;
   - checker matrix1 INTENSITY=0x0F, matrix0 SHUTDOWN=0x01.
3. N=8, D=4: 8 frames writing DIGIT_0..7 with 8'hA5 to all matrices, then i_display_screen_matrix pulse -> each checker's digit registers read 8'hA5; checker reports 8 frames received per matrix; busy=1036 cycles per frame.
4. Start held high continuously, D=1, N=1 -> back-to-back frames with exactly one IDLE cycle between the DONE cycle and the next busy; one done per frame; no extra frames from starts issued while busy.
5. Change i_data in mid-frame -> the shifted bits equal the value captured at start.
6. rst_n=0 pulsed during SHIFT_HIGH of bit 10 -> outputs idle the next cycle, no done; a following full frame latches correctly in the checker.
